// File: rtl/fsm_job_scheduler_if.sv
// ============================================================================
// Module  : fsm_job_scheduler_if
// Brief   : Requester-side job bus for fsm_job_scheduler (requests in, results out).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fsm_job_scheduler_if #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LW   = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*W-1:0]  data;
  logic [NREQ*LW-1:0] len;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               done;
  logic [2:0]         done_id;
  logic [1:0]         res_state;
  logic [CW-1:0]      res_cnt;

  modport master (
    output req, data, len,
    input  gnt, busy, done, done_id, res_state, res_cnt
  );

  modport slave (
    input  req, data, len,
    output gnt, busy, done, done_id, res_state, res_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fsm_job_scheduler.sv
// ============================================================================
// Module  : fsm_job_scheduler
// Brief   : Arbitrates NREQ requesters onto one serial 4-state recognizer engine.
//           Define FSM_SCHED_PRIO_EN for fixed lowest-index priority instead of
//           round-robin arbitration.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fsm_job_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LW   = 4,
  parameter int CW   = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fsm_job_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    E0 = 2'b00,
    E1 = 2'b01,
    E2 = 2'b10,
    E3 = 2'b11
  } eng_t;

  localparam logic [LW-1:0] c_LEN_MAX = LW'(W);

  state_t            r_state;
  state_t            w_state_nxt;
  eng_t              r_eng;
  eng_t              w_eng_nxt;
  logic [2:0]        r_k;
  logic [W-1:0]      r_shift;
  logic [LW-1:0]     r_left;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_done;
  logic [2:0]        r_done_id;
  logic [1:0]        r_res_state;
  logic [CW-1:0]     r_res_cnt;
  logic              w_busy;
  logic              w_found;
  logic [2:0]        w_win;
  logic [W-1:0]      w_data_k;
  logic [LW-1:0]     w_len_k;
  logic [LW-1:0]     w_len_clamp;

`ifdef FSM_SCHED_PRIO_EN
  always_comb begin
    w_found = 1'b0;
    w_win   = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        w_found = 1'b1;
        w_win   = 3'(i);
      end
    end
  end
`else
  logic [2:0]      r_rr;
  logic [NREQ-1:0] w_rot;
  logic [2:0]      w_pos;
  logic [3:0]      w_sum;

  // Rotate the request vector so the search always starts at bit 0.
  always_comb begin
    w_rot   = NREQ'({bus.req, bus.req} >> r_rr);
    w_found = |bus.req;
    w_pos   = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = 3'(i);
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_pos};
    w_win = 3'((w_sum >= 4'(NREQ)) ? (w_sum - 4'(NREQ)) : w_sum);
  end
`endif

  always_comb begin
    w_data_k    = bus.data[int'(w_win) * W +: W];
    w_len_k     = bus.len[int'(w_win) * LW +: LW];
    w_len_clamp = (w_len_k > c_LEN_MAX) ? c_LEN_MAX : w_len_k;
  end

  always_comb begin
    case (r_eng)
      E0:      w_eng_nxt = r_shift[0] ? E1 : E2;
      E1:      w_eng_nxt = r_shift[0] ? E0 : E1;
      E2:      w_eng_nxt = E1;
      default: w_eng_nxt = E0;
    endcase
    w_cnt_nxt = ((w_eng_nxt == E1) && (r_cnt != '1)) ? (r_cnt + CW'(1)) : r_cnt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (w_found) w_state_nxt = (w_len_clamp == '0) ? S_REPORT : S_RUN;
      S_RUN:    if (r_left == LW'(1)) w_state_nxt = S_REPORT;
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers load on the edge entering REPORT so they are valid with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_eng       <= E0;
      r_k         <= 3'd0;
      r_shift     <= '0;
      r_left      <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_done      <= 1'b0;
      r_done_id   <= 3'd0;
      r_res_state <= 2'b00;
      r_res_cnt   <= '0;
`ifndef FSM_SCHED_PRIO_EN
      r_rr        <= 3'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_k     <= w_win;
            r_shift <= w_data_k;
            r_left  <= w_len_clamp;
            r_eng   <= E0;
            r_cnt   <= '0;
            r_gnt   <= NREQ'(1) << w_win;
            if (w_len_clamp == '0) begin
              r_done      <= 1'b1;
              r_done_id   <= w_win;
              r_res_state <= E0;
              r_res_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          r_eng   <= w_eng_nxt;
          r_shift <= r_shift >> 1;
          r_left  <= r_left - LW'(1);
          r_cnt   <= w_cnt_nxt;
          if (r_left == LW'(1)) begin
            r_done      <= 1'b1;
            r_done_id   <= r_k;
            r_res_state <= w_eng_nxt;
            r_res_cnt   <= w_cnt_nxt;
          end
        end
        S_REPORT: begin
          r_gnt <= '0;
`ifndef FSM_SCHED_PRIO_EN
          r_rr  <= (r_k == 3'(NREQ - 1)) ? 3'd0 : (r_k + 3'd1);
`endif
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = w_busy;
  assign bus.done      = r_done;
  assign bus.done_id   = r_done_id;
  assign bus.res_state = r_res_state;
  assign bus.res_cnt   = r_res_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fsm_job_scheduler.sv
// ============================================================================
// Module  : tb_fsm_job_scheduler
// Brief   : Self-checking bench for fsm_job_scheduler (directed table + random jobs).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fsm_job_scheduler;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LW   = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_ptr = 0;

  fsm_job_scheduler_if #(.NREQ(NREQ), .W(W), .LW(LW), .CW(CW)) bus();

  fsm_job_scheduler #(.NREQ(NREQ), .W(W), .LW(LW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] dv;
    logic [15:0] lv;
    bit          hold;
    bit          scr;
    int          win_rr;
    logic [1:0]  st_rr;
    logic [3:0]  cnt_rr;
    int          win_pr;
    logic [1:0]  st_pr;
    logic [3:0]  cnt_pr;
    int          nbits;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level reference: winner by arbitration rule, then walk the engine bit by bit.
  function automatic void model(input logic [3:0] rq, input logic [31:0] dv,
                                input logic [15:0] lv, output int w, output logic [1:0] st,
                                output logic [3:0] c, output int nb);
    int nxt [4][2];
    int eng;
    int L;
    logic [7:0] d;
    nxt = '{'{2, 1}, '{1, 0}, '{1, 1}, '{0, 0}};
    w = 0;
`ifdef FSM_SCHED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--)
      if (((rq >> i) & 4'd1) != 4'd0) w = i;
`else
    for (int i = NREQ - 1; i >= 0; i--)
      if (((rq >> ((m_ptr + i) % NREQ)) & 4'd1) != 4'd0) w = (m_ptr + i) % NREQ;
`endif
    L = int'((lv >> (w * 4)) & 16'hF);
    if (L > W) L = W;
    d = 8'(dv >> (w * 8));
    eng = 0;
    c = 4'd0;
    for (int b = 0; b < L; b++) begin
      eng = nxt[eng][int'((d >> b) & 8'd1)];
      if (eng == 1 && c != 4'hF) c = c + 4'd1;
    end
    st = 2'(eng);
    nb = L;
  endfunction

  task automatic run_job(input logic [3:0] rq, input logic [31:0] dv, input logic [15:0] lv,
                         input bit hold, input bit scr, input int ew, input logic [1:0] es,
                         input logic [3:0] ec, input int el);
    int n;
    bus.req  = rq;
    bus.data = dv;
    bus.len  = lv;
    @(posedge clk); #1;
    chk("grant", 32'(bus.gnt), 32'(4'b0001 << ew));
    chk("busy_in_job", 32'(bus.busy), 32'd1);
    if (!hold) bus.req = '0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (scr) begin
        bus.req  = 4'($urandom);
        bus.data = $urandom;
        bus.len  = 16'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!hold) bus.req = '0;
    chk("done_latency", 32'(n), 32'(el));
    chk("done_id", 32'(bus.done_id), 32'(ew));
    chk("res_state", 32'(bus.res_state), 32'(es));
    chk("res_cnt", 32'(bus.res_cnt), 32'(ec));
    chk("gnt_at_done", 32'(bus.gnt), 32'(4'b0001 << ew));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("gnt_cleared", 32'(bus.gnt), 32'd0);
    chk("idle_gap", 32'(bus.busy), 32'd0);
    chk("res_state_hold", 32'(bus.res_state), 32'(es));
    chk("res_cnt_hold", 32'(bus.res_cnt), 32'(ec));
    m_ptr = (ew + 1) % NREQ;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   w;
    logic [1:0] st;
    logic [3:0] c;
    int   nb;
    logic [3:0]  rq;
    logic [31:0] dv;
    logic [15:0] lv;
    bit   seen;

    tbl[0] = '{4'b0001, 32'h0000_0005, 16'h0003, 1'b0, 1'b0, 0, 2'd0, 4'd2, 0, 2'd0, 4'd2, 3};
    tbl[1] = '{4'b0010, 32'h0000_0000, 16'h0040, 1'b0, 1'b0, 1, 2'd1, 4'd3, 1, 2'd1, 4'd3, 4};
    tbl[2] = '{4'b1111, 32'h0001_0001, 16'h1111, 1'b1, 1'b0, 0, 2'd1, 4'd1, 0, 2'd1, 4'd1, 1};
    tbl[3] = '{4'b1111, 32'h0001_0001, 16'h1111, 1'b1, 1'b0, 1, 2'd2, 4'd0, 0, 2'd1, 4'd1, 1};
    tbl[4] = '{4'b1111, 32'h0001_0001, 16'h1111, 1'b1, 1'b0, 2, 2'd1, 4'd1, 0, 2'd1, 4'd1, 1};
    tbl[5] = '{4'b1111, 32'h0001_0001, 16'h1111, 1'b1, 1'b0, 3, 2'd2, 4'd0, 0, 2'd1, 4'd1, 1};
    tbl[6] = '{4'b1111, 32'h0001_0001, 16'h1111, 1'b0, 1'b0, 0, 2'd1, 4'd1, 0, 2'd1, 4'd1, 1};
    tbl[7] = '{4'b0001, 32'h0000_00FF, 16'h000F, 1'b0, 1'b0, 0, 2'd0, 4'd4, 0, 2'd0, 4'd4, 8};
    tbl[8] = '{4'b0100, 32'h00FF_0000, 16'h0000, 1'b0, 1'b0, 2, 2'd0, 4'd0, 2, 2'd0, 4'd0, 0};
    tbl[9] = '{4'b1000, 32'h0600_0000, 16'h3000, 1'b0, 1'b1, 3, 2'd0, 4'd1, 3, 2'd0, 4'd1, 3};

    bus.req  = '0;
    bus.data = '0;
    bus.len  = '0;
    #12;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_done_id", 32'(bus.done_id), 32'd0);
    chk("rst_res_state", 32'(bus.res_state), 32'd0);
    chk("rst_res_cnt", 32'(bus.res_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
`ifdef FSM_SCHED_PRIO_EN
      run_job(tbl[i].rq, tbl[i].dv, tbl[i].lv, tbl[i].hold, tbl[i].scr,
              tbl[i].win_pr, tbl[i].st_pr, tbl[i].cnt_pr, tbl[i].nbits);
`else
      run_job(tbl[i].rq, tbl[i].dv, tbl[i].lv, tbl[i].hold, tbl[i].scr,
              tbl[i].win_rr, tbl[i].st_rr, tbl[i].cnt_rr, tbl[i].nbits);
`endif
      if (i == 1) begin
        // Abort a long job mid-RUN; pointer and results must return to reset values.
        bus.req  = 4'b0100;
        bus.data = 32'hFFFF_FFFF;
        bus.len  = 16'h8888;
        @(posedge clk); #1;
        chk("abort_pre_gnt", 32'(bus.gnt), 32'h4);
        bus.req = '0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_done_id", 32'(bus.done_id), 32'd0);
        chk("abort_res_state", 32'(bus.res_state), 32'd0);
        chk("abort_res_cnt", 32'(bus.res_cnt), 32'd0);
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
        rst = 1'b1;
        repeat (12) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
        chk("abort_no_done", 32'(seen), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
        m_ptr = 0;
      end
    end

    for (int j = 0; j < 40; j++) begin
      rq = 4'($urandom_range(1, 15));
      dv = $urandom;
      lv = 16'($urandom);
      model(rq, dv, lv, w, st, c, nb);
      run_job(rq, dv, lv, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), w, st, c, nb);
    end
    bus.req = '0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
